// File: rtl/burst_pkg.sv
// burst_pkg: shared types and constants for the burst packetizer
package burst_pkg;
  localparam int BURST_DATA_W = 32;
  localparam int BURST_MAX_BEATS = 15;
  typedef enum logic {IDLE, COLLECT} bp_state_t;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [BURST_DATA_W-1:0] data;
  } bp_entry_t;
endpackage

// File: rtl/burst_sync_fifo.sv
// burst_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers
module burst_sync_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  din,
  input  logic          rd_en,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // pointers advance on accepted push/pop; reset discards all contents
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, wr_ok};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, rd_ok};
    end
  // storage is never reset; the empty gate on dout hides stale words
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/burst_packetizer.sv
// burst_packetizer: frames controller words with sop/eop and buffers them with burst-granular backpressure
module burst_packetizer
  import burst_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int MIN_FREE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  input  logic                     in_first_beat,
  input  logic                     in_burst_done,
  output logic                     first_ack,
  output logic [31:0]              out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              burst_cnt,
  output logic                     overflow,
  output logic                     proto_err,
  input  logic                     clr_status
);
  localparam int LW = $clog2(DEPTH) + 1;
  bp_state_t state;
  logic stage_sop;
  logic [BURST_DATA_W-1:0] stage_data;
  logic ack_sent, collect, push, pop, full, empty, ack_ok;
  bp_entry_t din, dout;
  assign collect = state == COLLECT;
  assign push = collect && (in_valid || in_burst_done);
  assign pop = out_valid && out_ready;
  assign din = '{sop: stage_sop, eop: in_burst_done, data: stage_data};
  assign ack_ok = in_first_beat && !ack_sent && (LW'(DEPTH) - fill_level >= LW'(MIN_FREE));
  assign out_valid = !empty;
  assign out_sop = dout.sop;
  assign out_eop = dout.eop;
  assign out_data = dout.data;
  burst_sync_fifo #(.W($bits(bp_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(push),
    .din(din),
    .rd_en(pop),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(fill_level)
  );
  // stage keeps the newest word until the next word or burst end decides its eop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stage_sop <= 1'b0;
      stage_data <= '0;
    end else if (in_valid) begin
      state <= COLLECT;
      stage_sop <= !collect || in_burst_done;
      stage_data <= in_data;
    end else if (in_burst_done) state <= IDLE;
  // burst count, sticky errors and the once-per-episode first_ack pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      burst_cnt <= '0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
      first_ack <= 1'b0;
      ack_sent <= 1'b0;
    end else begin
      burst_cnt <= burst_cnt + {15'd0, push && in_burst_done};
      overflow <= (push && full && !pop) || (overflow && !clr_status);
      proto_err <= (in_burst_done && (in_valid || !collect)) || (proto_err && !clr_status);
      first_ack <= ack_ok;
      ack_sent <= in_first_beat && (ack_sent || ack_ok);
    end
endmodule

// File: doc/burst_packetizer.md
# burst_packetizer

Downstream stage of the burst controller: captures each registered output word (`data_out`/`data_ready`), frames it with start-of-packet/end-of-packet tags, and buffers it in a FIFO for a valid/ready consumer. It also produces the controller's `first_ack`, withholding it until the FIFO can absorb a whole burst. This gives burst-granular backpressure, because the controller itself cannot be stalled mid-burst.

## Interface
- `DEPTH`, 32: FIFO entries; power of 2, ≥ 4.
- `MIN_FREE`, 16: free entries required before `first_ack` is issued; must be ≤ DEPTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_data`  in  32  word from controller `data_out`.
- `in_valid`  in  1  one-cycle pulse from controller `data_ready`.
- `in_first_beat`  in  1  level from controller `first_beat`.
- `in_burst_done`  in  1  one-cycle pulse from controller `burst_done`.
- `first_ack`  out  1  one-cycle acknowledge to controller.
- `out_data`  out  32  FIFO head word.
- `out_sop`  out  1  head word is first of burst.
- `out_eop`  out  1  head word is last of burst.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head.
- `fill_level`  out  $clog2(DEPTH)+1  entries in FIFO (stage excluded).
- `burst_cnt`  out  16  completed bursts; wraps at 0xFFFF→0.
- `overflow`  out  1  sticky; a push was dropped.
- `proto_err`  out  1  sticky; protocol violation seen.
- `clr_status`  in  1  synchronous clear of `overflow` and `proto_err`.

## Operation
- FSM `IDLE` / `COLLECT`; reset → `IDLE`.
- Stage register holds the most recent word and its sop flag.
  - Tagging is deferred because `in_burst_done` arrives one cycle after the last `in_valid`.
- Push entry = {sop, eop, data}, 34 bits.
- `in_valid` in `IDLE`:
  - word → stage with sop=1.
  - FSM → `COLLECT`.
- `in_valid` in `COLLECT`:
  - if stage is full, push the staged word with eop=0.
  - new word → stage with sop=0.
- `in_burst_done` in `COLLECT`, no `in_valid`:
  - push the staged word with eop=1; stage empties.
  - `burst_cnt`+1.
  - FSM → `IDLE`.
- `in_burst_done` in `IDLE`, or with the stage empty:
  - set `proto_err`.
  - nothing is pushed; FSM stays or returns to `IDLE`.
- `in_valid` and `in_burst_done` in the same cycle:
  - set `proto_err`.
  - push the staged word with eop=1 and increment `burst_cnt`.
  - new word → stage with sop=1; FSM stays `COLLECT`.
- `first_ack` handshake:
  - `first_ack` is registered.
  - It pulses for one cycle when `in_first_beat`=1, `ack_sent`=0 and free entries ≥ MIN_FREE.
  - Free entries = DEPTH − `fill_level`, evaluated in the prior cycle.
  - `ack_sent` sets with the pulse and clears when `in_first_beat`=0.
  - Never two pulses per first-beat episode.
- Overflow:
  - A push while full with no simultaneous pop drops the entry and sets `overflow`.
  - If that entry carried eop, `burst_cnt` still increments.
  - Push and pop in the same cycle while full are both accepted.
- Pop occurs on `out_valid && out_ready`.
- `clr_status` and a new error in the same cycle: the error wins, flag stays 1.

## Timing
- Reset values:
  - `first_ack`, `out_valid`, `out_sop`, `out_eop`, `overflow`, `proto_err` = 0.
  - `out_data`, `fill_level`, `burst_cnt` = 0.
  - Stage empty, FSM `IDLE`, `ack_sent`=0.
- `rst_n` assertion mid-burst discards the stage and all FIFO contents immediately.
- Latency:
  - Non-last word: visible at `out_*` the cycle after the next `in_valid`.
  - Last word: `in_valid` at cycle c, `in_burst_done` at c+1, `out_valid` at c+2 (empty FIFO).
- FIFO is show-ahead: head is combinational from memory; `out_valid` = !empty.
- `first_ack` is asserted one cycle after its qualifying condition.
- `fill_level` updates one cycle after each push/pop edge.

## Structure
- Package `burst_pkg` holds:
  - `bp_state_t` enum (`IDLE`, `COLLECT`).
  - `bp_entry_t` struct {sop, eop, data[31:0]}.
  - `BURST_DATA_W`=32.
  - `BURST_MAX_BEATS`=15.
- Sub-module `burst_sync_fifo`: parameterised width and depth, show-ahead, reports full/empty/level.
  - Pointers are $clog2(DEPTH)+1 bits with wrap bit.
  - Full and empty are decoded from the pointer MSBs.
- Top level contains the FSM, stage register, ack logic and status.

## Test plan
- Burst A1=0x11, A2=0x22, A3=0x33, then `in_burst_done`, `out_ready`=1 → outputs 0x11 (sop=1,eop=0), 0x22 (0,0), 0x33 (0,1); `burst_cnt`=1.
- One-word burst 0xDEADBEEF + `in_burst_done` → single entry with sop=1, eop=1; `out_valid` two cycles after `in_valid`.
- `out_ready`=0, pre-load 17 entries (DEPTH=32, MIN_FREE=16), raise `in_first_beat` → no `first_ack`; pop 1 entry → `first_ack` pulses exactly once; hold `in_first_beat` → no second pulse.
- `out_ready`=0, fill to 32 entries, push one more → dropped, `overflow`=1, `fill_level`=32; pulse `clr_status` → `overflow`=0.
- `in_burst_done` in `IDLE` → `proto_err`=1, `fill_level` unchanged, `burst_cnt` unchanged.
- Two words pushed, `rst_n` low mid-burst → `out_valid`=0, `fill_level`=0, `first_ack`=0 immediately; next burst is framed with sop=1 correctly.
